// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults for the fetch stage and the IF/ID entry layout.
// Queue entries are packed as {instruction, pc_next}, with the instruction in the upper bits.
package fetch_queue_unit_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int INSTR_W_DEF  = 16;
    localparam int PC_STEP_DEF  = 2;
    localparam int RESET_PC_DEF = 0;
    localparam int DEPTH_DEF    = 4;
    localparam int MAX_OUT_DEF  = 4;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Prefetch queue: synchronous FIFO with flush, registered storage and an occupancy count.
// Flush beats push/pop; a push and a pop in the same cycle leave the count unchanged.
module sync_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int WIDTH = INSTR_W_DEF + ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = cnt_w(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push  = i_push & ~i_flush;
    assign w_pop   = i_pop & ~i_flush & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // The issue credit upstream must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_push && !w_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: in-order requests to instruction memory, prefetch queue to decode,
// branch redirects that discard stale in-flight responses, halt, and a sticky protocol error.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = DEPTH_DEF,
    parameter int                MAX_OUT  = MAX_OUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic               protocol_error
);

    localparam int OW = cnt_w(MAX_OUT);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = OW + CW + 1;
    localparam int EW = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [OW-1:0]     r_outstanding;
    logic [OW-1:0]     r_drop_cnt;
    logic              r_protocol_error;
    logic [CW-1:0]     w_q_count;
    logic [EW-1:0]     w_head;
    logic [SW-1:0]     w_reserved;
    logic              w_credit_ok;
    logic              w_req_fire;
    logic              w_rsp_err;
    logic              w_rsp_ok;
    logic              w_push;
    logic              w_pop;

    // Both channels transfer only on a cycle where valid and ready are high together; valid never
    // waits on ready. Slots are reserved for every live in-flight request; a same-cycle pop adds no credit.
    assign w_reserved     = SW'(w_q_count) + SW'(r_outstanding) - SW'(r_drop_cnt);
    assign w_credit_ok    = w_reserved < SW'(DEPTH);
    assign imem_req_valid = reset & ~redirect_valid & ~halt
                          & (r_outstanding < OW'(MAX_OUT)) & w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // An unsolicited response only raises the error flag; it is never queued.
    assign w_rsp_err = imem_rsp_valid & (r_outstanding == '0);
    assign w_rsp_ok  = imem_rsp_valid & ~w_rsp_err;
    assign w_push    = w_rsp_ok & ~redirect_valid & (r_drop_cnt == '0);

    assign id_valid       = reset & (w_q_count != '0) & ~redirect_valid;
    assign w_pop          = id_valid & id_ready;
    assign id_instruction = w_head[EW-1 -: INSTR_W];
    assign id_pc_next     = w_head[ADDR_W-1:0];
    assign protocol_error = r_protocol_error;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({imem_rsp_data, r_rsp_pc + STEP}),
        .o_head  (w_head),
        .o_count (w_q_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fetch_pc       <= RESET_PC;
            r_rsp_pc         <= RESET_PC;
            r_outstanding    <= '0;
            r_drop_cnt       <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_addr;
                r_rsp_pc   <= redirect_addr;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
                if (w_push)     r_rsp_pc   <= r_rsp_pc + STEP;
            end

            if (w_req_fire && !w_rsp_ok)      r_outstanding <= r_outstanding + OW'(1);
            else if (!w_req_fire && w_rsp_ok) r_outstanding <= r_outstanding - OW'(1);

            // Every request still in flight at a redirect belongs to the old path.
            if (redirect_valid)                     r_drop_cnt <= r_outstanding - OW'(w_rsp_ok);
            else if (w_rsp_ok && r_drop_cnt != '0)  r_drop_cnt <= r_drop_cnt - OW'(1);

            if (w_rsp_err) r_protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an in-order memory model with random latency and a scoreboard of
// the addresses the program should deliver to decode, with directed scenarios and a random soak.
module tb_fetch_queue_unit;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        halt;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instruction;
  logic [15:0] id_pc_next;
  logic        protocol_error;

  fetch_queue_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .PC_STEP  (2),
    .RESET_PC (16'h0000),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc_next     (id_pc_next),
    .protocol_error (protocol_error)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];       // live requested addresses not yet delivered to decode, in order
  logic [15:0] exp_fetch;      // address the next request must carry
  logic        perr_exp;

  logic [15:0] mem_addr_q[$];  // memory model: accepted requests awaiting response
  int          mem_due_q[$];
  int          last_due;
  int          lat_min, lat_max;
  logic        rsp_en, force_rsp;
  logic [15:0] key;

  logic        t_fire, t_pop, t_req_valid, t_id_valid, t_rsp;
  logic [15:0] t_fire_addr, t_instr, t_pc_next;
  int          t_cyc;

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    int          due;
    logic [15:0] e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    if (force_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 16'hDEAD;
    end else if (rsp_en && mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q[0] ^ key;
    end
    #1;
    t_cyc       = cyc;
    t_req_valid = imem_req_valid;
    t_id_valid  = id_valid;
    t_fire      = imem_req_valid & imem_req_ready;
    t_pop       = id_valid & id_ready;
    t_rsp       = imem_rsp_valid;
    t_fire_addr = imem_req_addr;
    t_instr     = id_instruction;
    t_pc_next   = id_pc_next;

    if (t_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected cyc=%0d got instr=%h pc_next=%h, required no valid entry", cyc, id_instruction, id_pc_next);
      end else begin
        e = exp_q.pop_front();
        if (id_instruction !== (e ^ key) || id_pc_next !== e + 16'd2) begin
          errors++;
          $display("FAIL pop_data cyc=%0d got instr=%h pc_next=%h, required instr=%h pc_next=%h",
                   cyc, id_instruction, id_pc_next, e ^ key, e + 16'd2);
        end
      end
    end

    if (t_fire) begin
      checks++;
      if (imem_req_addr !== exp_fetch) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h required=%h", cyc, imem_req_addr, exp_fetch);
      end
      exp_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 16'd2;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(due);
    end

    if (t_rsp && !force_rsp) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end

    if (redirect_valid) begin
      checks++;
      if (t_req_valid !== 1'b0 || t_id_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_quiet cyc=%0d got req_valid=%b id_valid=%b, required 0 0", cyc, t_req_valid, t_id_valid);
      end
      exp_q.delete();
      exp_fetch = redirect_addr;
    end

    checks++;
    if (exp_q.size() > DEPTH || mem_addr_q.size() > MAX_OUT) begin
      errors++;
      $display("FAIL credit cyc=%0d got live=%0d outstanding=%0d, required <=%0d and <=%0d",
               cyc, exp_q.size(), mem_addr_q.size(), DEPTH, MAX_OUT);
    end

    checks++;
    if (protocol_error !== perr_exp) begin
      errors++;
      $display("FAIL protocol_error cyc=%0d got=%b required=%b", cyc, protocol_error, perr_exp);
    end

    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    mem_addr_q.delete();
    mem_due_q.delete();
    last_due       = 0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    force_rsp      = 1'b0;
    tick();
    perr_exp = 1'b0;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || protocol_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got req_valid=%b id_valid=%b perr=%b, required 0 0 0",
               imem_req_valid, id_valid, protocol_error);
    end
    exp_q.delete();
    exp_fetch = 16'h0000;
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    int first_fire, first_valid, pops;
    logic [15:0] f_instr, f_pc;
    do_reset();
    key = 16'h0000; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    first_fire = -1; first_valid = -1; f_instr = 16'hxxxx; f_pc = 16'hxxxx;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (t_fire && first_fire < 0) first_fire = t_cyc;
      if (t_id_valid && first_valid < 0) begin
        first_valid = t_cyc; f_instr = t_instr; f_pc = t_pc_next;
      end
    end
    checks++;
    if (first_fire < 0 || first_valid != first_fire + 2) begin
      errors++;
      $display("FAIL first_latency got fire=%0d valid=%0d, required valid=fire+2", first_fire, first_valid);
    end
    checks++;
    if (f_instr !== 16'h0000 || f_pc !== 16'h0002) begin
      errors++;
      $display("FAIL first_entry got instr=%h pc_next=%h, required 0000 0002", f_instr, f_pc);
    end
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t_pop) pops++;
    end
    checks++;
    if (pops != 10) begin
      errors++;
      $display("FAIL stream_rate got %0d pops in 10 cycles, required 10", pops);
    end
  endtask

  task automatic test_backpressure();
    int fires, pops, unstable;
    logic have_head;
    logic [15:0] h_instr, h_pc;
    do_reset();
    key = 16'h0000; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; id_ready = 1'b0; rsp_en = 1'b1;
    fires = 0; unstable = 0; have_head = 1'b0; h_instr = 16'h0; h_pc = 16'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t_fire) fires++;
      if (t_id_valid) begin
        if (!have_head) begin
          have_head = 1'b1; h_instr = t_instr; h_pc = t_pc_next;
        end else if (t_instr !== h_instr || t_pc_next !== h_pc) begin
          unstable++;
        end
      end
    end
    checks++;
    if (fires != 4) begin
      errors++;
      $display("FAIL bp_accepts got=%0d required=4", fires);
    end
    checks++;
    if (t_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_valid got=%b required=0", t_req_valid);
    end
    checks++;
    if (!have_head || unstable != 0 || h_pc !== 16'h0002) begin
      errors++;
      $display("FAIL bp_head_stable got seen=%b changes=%0d pc_next=%h, required 1 0 0002", have_head, unstable, h_pc);
    end
    id_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (t_pop) pops++;
    end
    checks++;
    if (pops != 4) begin
      errors++;
      $display("FAIL bp_drain got=%0d required=4", pops);
    end
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (t_fire) fires++;
    end
    checks++;
    if (fires == 0) begin
      errors++;
      $display("FAIL bp_resume got=0 requests, required >0");
    end
  endtask

  task automatic test_redirect_stale();
    int rcyc, first_valid;
    logic [15:0] f_instr, f_pc;
    do_reset();
    key = 16'h0000; lat_min = 4; lat_max = 4;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    ticks(3);
    checks++;
    if (mem_addr_q.size() != 3) begin
      errors++;
      $display("FAIL stale_outstanding got=%0d required=3", mem_addr_q.size());
    end
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    tick();
    rcyc = t_cyc;
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (!t_fire || t_fire_addr !== 16'h0100) begin
      errors++;
      $display("FAIL redirect_next_req got fire=%b addr=%h, required 1 0100", t_fire, t_fire_addr);
    end
    first_valid = -1; f_instr = 16'h0; f_pc = 16'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (t_id_valid && first_valid < 0) begin
        first_valid = t_cyc; f_instr = t_instr; f_pc = t_pc_next;
      end
    end
    checks++;
    if (first_valid < rcyc + 3 || f_instr !== 16'h0100 || f_pc !== 16'h0102) begin
      errors++;
      $display("FAIL redirect_first got cyc=%0d instr=%h pc_next=%h, required cyc>=%0d 0100 0102",
               first_valid, f_instr, f_pc, rcyc + 3);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int pops;
    logic rsp_seen;
    do_reset();
    key = 16'h0000; lat_min = 2; lat_max = 2;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    ticks(8);
    redirect_valid = 1'b1; redirect_addr = 16'h0200;
    tick();
    rsp_seen = t_rsp;
    redirect_valid = 1'b0;
    checks++;
    if (rsp_seen !== 1'b1 || t_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle got rsp=%b id_valid=%b, required 1 0", rsp_seen, t_id_valid);
    end
    tick();
    checks++;
    if (t_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_flush got id_valid=%b required=0", t_id_valid);
    end
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (t_pop) pops++;
    end
    checks++;
    if (pops < 5) begin
      errors++;
      $display("FAIL same_cycle_resume got %0d pops, required >=5", pops);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] fa[2];
    logic [15:0] pa[2];
    int nf, np;
    do_reset();
    key = 16'h0000; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    nf = 0; np = 0; fa[0] = 16'h1; fa[1] = 16'h1; pa[0] = 16'h1; pa[1] = 16'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t_fire && nf < 2) begin fa[nf] = t_fire_addr; nf++; end
      if (t_pop && np < 2)  begin pa[np] = t_pc_next; np++; end
    end
    checks++;
    if (fa[0] !== 16'hFFFE || fa[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_req got %h %h, required FFFE 0000", fa[0], fa[1]);
    end
    checks++;
    if (pa[0] !== 16'h0000 || pa[1] !== 16'h0002) begin
      errors++;
      $display("FAIL wrap_pc_next got %h %h, required 0000 0002", pa[0], pa[1]);
    end
  endtask

  task automatic test_halt_and_error();
    int owed, fires, pops;
    do_reset();
    key = 16'h0000; lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    ticks(6);
    halt = 1'b1;
    owed = exp_q.size();
    fires = 0; pops = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (t_fire) fires++;
      if (t_pop) pops++;
    end
    checks++;
    if (fires != 0 || pops != owed || owed == 0) begin
      errors++;
      $display("FAIL halt_drain got fires=%0d pops=%0d, required 0 and %0d (nonzero)", fires, pops, owed);
    end
    redirect_valid = 1'b1; redirect_addr = 16'h0300;
    tick();
    redirect_valid = 1'b0;
    fires = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (t_fire) fires++;
    end
    checks++;
    if (fires != 0 || t_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_redirect_idle got fires=%0d id_valid=%b, required 0 0", fires, t_id_valid);
    end
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    perr_exp  = 1'b1;
    ticks(3);
    checks++;
    if (protocol_error !== 1'b1 || t_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL unsolicited got perr=%b id_valid=%b, required 1 0", protocol_error, t_id_valid);
    end
    halt = 1'b0;
    tick();
    checks++;
    if (!t_fire || t_fire_addr !== 16'h0300) begin
      errors++;
      $display("FAIL halt_resume got fire=%b addr=%h, required 1 0300", t_fire, t_fire_addr);
    end
    ticks(3);
  endtask

  task automatic test_reset_mid();
    key = 16'h0000; lat_min = 2; lat_max = 2;
    imem_req_ready = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
    ticks(5);
    do_reset();
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_perr got=%b required=0", protocol_error);
    end
    tick();
    checks++;
    if (!t_fire || t_fire_addr !== 16'h0000 || t_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart got fire=%b addr=%h id_valid=%b, required 1 0000 0", t_fire, t_fire_addr, t_id_valid);
    end
    ticks(6);
  endtask

  task automatic test_random();
    int pops;
    do_reset();
    key = 16'($urandom_range(0, 65535));
    lat_min = 1; lat_max = 4;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_addr  = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      tick();
      if (t_pop) pops++;
    end
    redirect_valid = 1'b0; halt = 1'b0; id_ready = 1'b1; rsp_en = 1'b1; imem_req_ready = 1'b1;
    ticks(20);
    checks++;
    if (pops < 300) begin
      errors++;
      $display("FAIL random_progress got %0d pops, required >=300", pops);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0;
    redirect_valid = 1'b0; redirect_addr = 16'h0; halt = 1'b0; id_ready = 1'b0;
    rsp_en = 1'b1; force_rsp = 1'b0; key = 16'h0; lat_min = 1; lat_max = 1;
    perr_exp = 1'b0; exp_fetch = 16'h0; last_due = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_same_cycle();
    test_wrap();
    test_halt_and_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
